// File: rtl/multi_channel_one_shot.sv
// ---------------------------------------------------------------------------
// multi_channel_one_shot
//
// Purpose:
//   N-channel clocked one-shot. Each channel synchronises an asynchronous
//   input, watches for a selectable edge (off / rising / falling / both) and
//   emits a pulse PULSE_WIDTH clock cycles long for every accepted edge.
//   Used as the shared front end for buttons, paddle switches and sync
//   strobes.
//
// Optional feature:
//   ONESHOT_DEBOUNCE_EN - when defined, a per-channel debounce filter sits
//   between the synchroniser and the edge detector. The filtered level only
//   follows the input after it has differed for DEBOUNCE_CYC consecutive
//   cycles. Left undefined, there is no filter and DEBOUNCE_CYC is only
//   folded into the arming delay calculation (with a zero weight).
//
// Ports:
//   CLOCK         in   1           system clock, all logic on posedge
//   Reset         in   1           synchronous, active-high
//   InputPulse    in   CHANNELS    asynchronous inputs, one bit per channel
//   Mode          in   2*CHANNELS  Mode[2ch+1:2ch]: 00 off, 01 rise, 10 fall, 11 both
//   ClearOverrun  in   CHANNELS    level-sensitive clear of sticky Overrun
//   OneShot       out  CHANNELS    registered pulse outputs
//   Busy          out  CHANNELS    registered, high while the pulse counter is nonzero
//   Overrun       out  CHANNELS    sticky, edge seen during an active pulse (RETRIGGER=0)
// ---------------------------------------------------------------------------
module multi_channel_one_shot #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_WIDTH  = 1,
  parameter int RETRIGGER    = 0,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                  CLOCK,
  input  logic                  Reset,
  input  logic [CHANNELS-1:0]   InputPulse,
  input  logic [2*CHANNELS-1:0] Mode,
  input  logic [CHANNELS-1:0]   ClearOverrun,
  output logic [CHANNELS-1:0]   OneShot,
  output logic [CHANNELS-1:0]   Busy,
  output logic [CHANNELS-1:0]   Overrun
);

`ifdef ONESHOT_DEBOUNCE_EN
  localparam int DEBOUNCE_ON = 1;
`else
  localparam int DEBOUNCE_ON = 0;
`endif

  localparam int CW = $clog2(PULSE_WIDTH + 1);
  localparam logic [CW-1:0] PW_VAL = CW'(PULSE_WIDTH);
  localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_ON * DEBOUNCE_CYC;
  localparam int AW = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] syncChain [CHANNELS];
  logic [CHANNELS-1:0]    syncOut;
  logic [CHANNELS-1:0]    edgeLevel;
  logic [CHANNELS-1:0]    prevLevel;
  logic [CHANNELS-1:0]    edgeHit;
  logic [CHANNELS-1:0]    overrunSet;
  logic [CW-1:0]          cnt [CHANNELS];
  logic [CW-1:0]          cntNext [CHANNELS];
  logic [AW-1:0]          armCnt;
  logic                   armed;

  // Synchroniser chain per channel. Bit 0 takes the raw input and each
  // posedge shifts it one stage towards the MSB, which is the synchronised
  // level. Written as a shift so a single-stage chain needs no special case.
  always_ff @(posedge CLOCK) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (Reset) begin
        syncChain[ch] <= '0;
      end else begin
        syncChain[ch] <= (syncChain[ch] << 1) | SYNC_STAGES'(InputPulse[ch]);
      end
    end
  end

  // Pick the synchronised level out of each chain.
  always_comb begin
    syncOut = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      syncOut[ch] = syncChain[ch][SYNC_STAGES-1];
    end
  end

`ifdef ONESHOT_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  logic [DW-1:0]       dbCnt [CHANNELS];
  logic [CHANNELS-1:0] filtLevel;

  // Debounce filter. The counter tracks how many consecutive cycles the
  // synchronised input has disagreed with the filtered level; any cycle of
  // agreement (a glitch ending) throws the count away. Only a full run of
  // DEBOUNCE_CYC disagreeing cycles moves the filtered level.
  always_ff @(posedge CLOCK) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (Reset) begin
        dbCnt[ch]     <= '0;
        filtLevel[ch] <= 1'b0;
      end else if (syncOut[ch] != filtLevel[ch]) begin
        if (dbCnt[ch] == DW'(DEBOUNCE_CYC - 1)) begin
          filtLevel[ch] <= syncOut[ch];
          dbCnt[ch]     <= '0;
        end else begin
          dbCnt[ch] <= dbCnt[ch] + DW'(1);
        end
      end else begin
        dbCnt[ch] <= '0;
      end
    end
  end

  assign edgeLevel = filtLevel;
`else
  assign edgeLevel = syncOut;
`endif

  // Arming after reset. The synchroniser (and filter, if present) starts at
  // zero, so a level already high at reset would otherwise look like a
  // rising edge once it propagates. Edges are ignored until the pipeline
  // has had time to fill and prevLevel has caught up with it.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      armCnt <= '0;
      armed  <= 1'b0;
    end else begin
      if (!armed) begin
        armCnt <= armCnt + AW'(1);
      end
      if (armCnt == AW'(ARM_CYCLES - 1)) begin
        armed <= 1'b1;
      end
    end
  end

  // Previous level register for the edge detector. It runs during arming
  // too, which is what lets a level present at reset settle silently.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      prevLevel <= '0;
    end else begin
      prevLevel <= edgeLevel;
    end
  end

  // Edge detection and pulse counter next-state. An edge on an idle channel
  // loads the full width. An edge on an active channel, including its last
  // cycle, either reloads the count (RETRIGGER) or is dropped and flagged as
  // an overrun. Mode is used directly and only matters at edge evaluation,
  // so switching a channel off never truncates a pulse already running.
  always_comb begin
    edgeHit    = '0;
    overrunSet = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cntNext[ch] = cnt[ch];
      edgeHit[ch] = armed &
                    (((edgeLevel[ch] & ~prevLevel[ch]) & Mode[2*ch]) |
                     ((~edgeLevel[ch] & prevLevel[ch]) & Mode[2*ch+1]));
      if (edgeHit[ch]) begin
        if ((cnt[ch] == '0) || (RETRIGGER != 0)) begin
          cntNext[ch] = PW_VAL;
        end else begin
          cntNext[ch]    = cnt[ch] - CW'(1);
          overrunSet[ch] = 1'b1;
        end
      end else if (cnt[ch] != '0) begin
        cntNext[ch] = cnt[ch] - CW'(1);
      end
    end
  end

  // Counter and output registers. OneShot and Busy are registered from the
  // next counter value so they line up with the counter being nonzero. A
  // new overrun outranks a clear requested in the same cycle.
  always_ff @(posedge CLOCK) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (Reset) begin
        cnt[ch]     <= '0;
        OneShot[ch] <= 1'b0;
        Busy[ch]    <= 1'b0;
        Overrun[ch] <= 1'b0;
      end else begin
        cnt[ch]     <= cntNext[ch];
        OneShot[ch] <= (cntNext[ch] != '0);
        Busy[ch]    <= (cntNext[ch] != '0);
        Overrun[ch] <= overrunSet[ch] | (Overrun[ch] & ~ClearOverrun[ch]);
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_one_shot.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_one_shot
//
// Purpose:
//   Self-checking bench for multi_channel_one_shot. Four instances share
//   CLOCK and Reset:
//     inst 0: PULSE_WIDTH=1, RETRIGGER=0  (arming, fall-only, both, off, last-cycle edge)
//     inst 1: PULSE_WIDTH=5, RETRIGGER=0  (pulse width, reset mid-pulse)
//     inst 2: PULSE_WIDTH=4, RETRIGGER=0  (overrun, clear priority)
//     inst 3: PULSE_WIDTH=4, RETRIGGER=1  (retrigger extension)
//   The stimulus process pushes the expected outputs per cycle into a queue;
//   a separate monitor pops each entry on its cycle and compares.
// ---------------------------------------------------------------------------
module tb_multi_channel_one_shot;

  typedef struct {
    int         cyc;
    int         inst;
    logic [3:0] os;
    logic [3:0] ov;
  } exp_t;

  logic       CLOCK = 1'b0;
  logic       Reset;
  logic [3:0] inp  [4];
  logic [7:0] mode [4];
  logic [3:0] clr  [4];
  logic [3:0] os   [4];
  logic [3:0] busy [4];
  logic [3:0] ov   [4];

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t expQ [$];

  // Free-running clock and a cycle counter stepped on every posedge.
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    cyc <= cyc + 1;
  end

  multi_channel_one_shot #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(1), .RETRIGGER(0)) dutA (
    .CLOCK(CLOCK), .Reset(Reset), .InputPulse(inp[0]), .Mode(mode[0]),
    .ClearOverrun(clr[0]), .OneShot(os[0]), .Busy(busy[0]), .Overrun(ov[0]));

  multi_channel_one_shot #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(5), .RETRIGGER(0)) dutB (
    .CLOCK(CLOCK), .Reset(Reset), .InputPulse(inp[1]), .Mode(mode[1]),
    .ClearOverrun(clr[1]), .OneShot(os[1]), .Busy(busy[1]), .Overrun(ov[1]));

  multi_channel_one_shot #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(4), .RETRIGGER(0)) dutC (
    .CLOCK(CLOCK), .Reset(Reset), .InputPulse(inp[2]), .Mode(mode[2]),
    .ClearOverrun(clr[2]), .OneShot(os[2]), .Busy(busy[2]), .Overrun(ov[2]));

  multi_channel_one_shot #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(4), .RETRIGGER(1)) dutD (
    .CLOCK(CLOCK), .Reset(Reset), .InputPulse(inp[3]), .Mode(mode[3]),
    .ClearOverrun(clr[3]), .OneShot(os[3]), .Busy(busy[3]), .Overrun(ov[3]));

  // Queue the expected OneShot/Busy and Overrun values of one instance for
  // every cycle in [c0, c1].
  task automatic expectRange(input int c0, input int c1, input int inst,
                             input logic [3:0] o, input logic [3:0] v);
    for (int c = c0; c <= c1; c++) begin
      expQ.push_back('{c, inst, o, v});
    end
  endtask

  // Drive all inputs of one instance.
  task automatic applyStimulus(input int inst, input logic [3:0] i,
                               input logic [7:0] m, input logic [3:0] c);
    inp[inst]  = i;
    mode[inst] = m;
    clr[inst]  = c;
  endtask

  // Return just after posedge n, so inputs change away from the clock edge.
  task automatic waitTo(input int n);
    while (cyc < n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  // Compare one expected entry against the live outputs.
  task automatic checkOutput(input exp_t e);
    compared++;
    if (os[e.inst] !== e.os) begin
      mismatched++;
      $display("[TB] FAIL oneShot inst%0d cyc%0d: got %h want %h", e.inst, e.cyc, os[e.inst], e.os);
    end
    compared++;
    if (busy[e.inst] !== e.os) begin
      mismatched++;
      $display("[TB] FAIL busy inst%0d cyc%0d: got %h want %h", e.inst, e.cyc, busy[e.inst], e.os);
    end
    compared++;
    if (ov[e.inst] !== e.ov) begin
      mismatched++;
      $display("[TB] FAIL overrun inst%0d cyc%0d: got %h want %h", e.inst, e.cyc, ov[e.inst], e.ov);
    end
  endtask

  // Monitor: on each negedge, pop and check every entry due this cycle.
  always @(negedge CLOCK) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc == cyc) begin
        checkOutput(expQ[i]);
        expQ.delete(i);
      end
    end
  end

  // Directed stimulus. Inputs change 1 time unit after posedge N; with two
  // sync stages the resulting pulse starts at posedge N+3.
  initial begin
    Reset = 1'b1;
    applyStimulus(0, 4'hF, 8'hFF, 4'h0);
    applyStimulus(1, 4'h0, 8'h55, 4'h0);
    applyStimulus(2, 4'h0, 8'h55, 4'h0);
    applyStimulus(3, 4'h0, 8'h55, 4'h0);
    expectRange(1, 12, 0, 4'h0, 4'h0);
    expectRange(1, 12, 1, 4'h0, 4'h0);
    expectRange(1, 12, 2, 4'h0, 4'h0);
    expectRange(1, 12, 3, 4'h0, 4'h0);

    waitTo(3);
    Reset = 1'b0;

    waitTo(10);
    applyStimulus(0, 4'hE, 8'hFE, 4'h0);
    expectRange(13, 13, 0, 4'h1, 4'h0);
    expectRange(14, 22, 0, 4'h0, 4'h0);
    applyStimulus(1, 4'h1, 8'h55, 4'h0);
    expectRange(13, 17, 1, 4'h1, 4'h0);
    expectRange(18, 62, 1, 4'h0, 4'h0);
    applyStimulus(2, 4'h1, 8'h55, 4'h0);
    applyStimulus(3, 4'h1, 8'h55, 4'h0);
    expectRange(13, 14, 2, 4'h1, 4'h0);
    expectRange(15, 16, 2, 4'h1, 4'h1);
    expectRange(17, 20, 2, 4'h0, 4'h1);
    expectRange(21, 32, 2, 4'h0, 4'h0);
    expectRange(13, 18, 3, 4'h1, 4'h0);
    expectRange(19, 32, 3, 4'h0, 4'h0);

    waitTo(11);
    applyStimulus(2, 4'h0, 8'h55, 4'h0);
    applyStimulus(3, 4'h0, 8'h55, 4'h0);
    waitTo(12);
    applyStimulus(2, 4'h1, 8'h55, 4'h0);
    applyStimulus(3, 4'h1, 8'h55, 4'h0);

    waitTo(20);
    applyStimulus(0, 4'h0, 8'hFE, 4'h0);
    expectRange(23, 23, 0, 4'hE, 4'h0);
    expectRange(24, 32, 0, 4'h0, 4'h0);
    applyStimulus(1, 4'h0, 8'h55, 4'h0);
    applyStimulus(2, 4'h0, 8'h55, 4'hF);
    applyStimulus(3, 4'h0, 8'h55, 4'hF);
    waitTo(21);
    applyStimulus(2, 4'h0, 8'h55, 4'h0);
    applyStimulus(3, 4'h0, 8'h55, 4'h0);

    waitTo(30);
    applyStimulus(0, 4'hF, 8'hFF, 4'h0);
    expectRange(33, 33, 0, 4'hF, 4'h0);
    expectRange(34, 52, 0, 4'h0, 4'h0);
    applyStimulus(2, 4'h1, 8'h55, 4'h0);
    applyStimulus(3, 4'h1, 8'h55, 4'h0);
    expectRange(33, 34, 2, 4'h1, 4'h0);
    expectRange(35, 36, 2, 4'h1, 4'h1);
    expectRange(37, 40, 2, 4'h0, 4'h1);
    expectRange(41, 64, 2, 4'h0, 4'h0);
    expectRange(33, 38, 3, 4'h1, 4'h0);
    expectRange(39, 64, 3, 4'h0, 4'h0);
    waitTo(31);
    applyStimulus(2, 4'h0, 8'h55, 4'h0);
    applyStimulus(3, 4'h0, 8'h55, 4'h0);
    waitTo(32);
    applyStimulus(2, 4'h1, 8'h55, 4'h0);
    applyStimulus(3, 4'h1, 8'h55, 4'h0);
    waitTo(33);
    applyStimulus(2, 4'h1, 8'h55, 4'hF);
    applyStimulus(3, 4'h1, 8'h55, 4'hF);
    waitTo(35);
    applyStimulus(2, 4'h1, 8'h55, 4'h0);
    applyStimulus(3, 4'h1, 8'h55, 4'h0);

    waitTo(40);
    applyStimulus(0, 4'h0, 8'h00, 4'h0);
    applyStimulus(2, 4'h1, 8'h55, 4'hF);
    applyStimulus(3, 4'h1, 8'h55, 4'hF);
    waitTo(41);
    applyStimulus(2, 4'h1, 8'h55, 4'h0);
    applyStimulus(3, 4'h1, 8'h55, 4'h0);

    waitTo(50);
    applyStimulus(0, 4'h1, 8'hFF, 4'h0);
    expectRange(53, 53, 0, 4'h1, 4'h0);
    expectRange(54, 56, 0, 4'h0, 4'h1);
    expectRange(57, 64, 0, 4'h0, 4'h0);
    waitTo(51);
    applyStimulus(0, 4'h0, 8'hFF, 4'h0);
    waitTo(56);
    applyStimulus(0, 4'h0, 8'hFF, 4'hF);
    waitTo(57);
    applyStimulus(0, 4'h0, 8'hFF, 4'h0);

    waitTo(60);
    applyStimulus(1, 4'h1, 8'hFF, 4'h0);
    expectRange(63, 64, 1, 4'h1, 4'h0);

    waitTo(64);
    Reset = 1'b1;
    expectRange(65, 88, 0, 4'h0, 4'h0);
    expectRange(65, 77, 1, 4'h0, 4'h0);
    expectRange(78, 82, 1, 4'h1, 4'h0);
    expectRange(83, 88, 1, 4'h0, 4'h0);
    expectRange(65, 88, 2, 4'h0, 4'h0);
    expectRange(65, 88, 3, 4'h0, 4'h0);
    waitTo(65);
    Reset = 1'b0;

    waitTo(75);
    applyStimulus(1, 4'h0, 8'hFF, 4'h0);

    waitTo(90);
    foreach (expQ[i]) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unchecked inst%0d cyc%0d: got none want checked", expQ[i].inst, expQ[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
